uart_tx: RTL and testbench

- UART serial transmitter: accepts a parallel byte with a valid strobe and shifts out a standard frame, one bit per clock.
- Frame is start bit (0), data LSB-first, optional parity, then stop bit (1).
- Sits between the system register/FIFO side and the TX pin. It is clocked by the baud-rate clock, so each clock cycle is one bit period.
- Raises busy while a frame is in flight and supports back-to-back frames with no idle gap.

---
 rtl/uart_tx.sv | 100 ++++++++++
 tb/tb_uart_tx.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// UART transmitter clocked at the bit rate: one clock edge per serial bit.
// Frame: start (0), DATA_WIDTH data bits LSB first, optional parity, stop (1).
// A new request sampled in the stop cycle starts the next frame without an idle gap.
module uart_tx #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic                  TX_OUT,
  output logic                  busy
);

  localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;

  logic [2:0]            state;
  logic [IDX_W-1:0]      bit_idx;
  logic [IDX_W-1:0]      next_idx;
  logic [DATA_WIDTH-1:0] data_r;
  logic                  par_en_r;
  logic                  par_bit_r;

  // Parity bit to send: XOR of the data, inverted for odd parity.
  function automatic logic parity_bit(input logic [DATA_WIDTH-1:0] d,
                                      input logic odd);
    return (^d) ^ odd;
  endfunction

  assign next_idx = bit_idx + IDX_W'(1);

  // Frame sequencer; the parity bit is resolved at latch time and forced to 0
  // when parity is disabled so an undriven PAR_TYP can never reach the line.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      bit_idx   <= '0;
      data_r    <= '0;
      par_en_r  <= 1'b0;
      par_bit_r <= 1'b0;
      TX_OUT    <= 1'b1;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE, STOP: begin
          if (Data_valid) begin
            data_r    <= P_DATA;
            par_en_r  <= PAR_EN;
            par_bit_r <= PAR_EN & parity_bit(P_DATA, PAR_TYP);
            state     <= START;
            TX_OUT    <= 1'b0;
            busy      <= 1'b1;
          end else begin
            state  <= IDLE;
            TX_OUT <= 1'b1;
            busy   <= 1'b0;
          end
        end
        START: begin
          state   <= DATA;
          bit_idx <= '0;
          TX_OUT  <= data_r[0];
        end
        DATA: begin
          if (bit_idx == LAST_IDX) begin
            if (par_en_r) begin
              state  <= PARITY;
              TX_OUT <= par_bit_r;
            end else begin
              state  <= STOP;
              TX_OUT <= 1'b1;
            end
          end else begin
            bit_idx <= next_idx;
            TX_OUT  <= data_r[next_idx];
          end
        end
        PARITY: begin
          state  <= STOP;
          TX_OUT <= 1'b1;
        end
        default: begin
          state  <= IDLE;
          TX_OUT <= 1'b1;
          busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: a frame-level queue model checked every cycle,
// plus literal per-bit expectations for the hand-worked frames.
module tb_uart_tx;

  logic       CLK = 1'b0;
  logic       rst;
  logic [7:0] P_DATA;
  logic       Data_valid;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic       TX_OUT;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  uart_tx #(.DATA_WIDTH(8)) dut (
    .CLK(CLK), .rst(rst), .P_DATA(P_DATA), .Data_valid(Data_valid),
    .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .TX_OUT(TX_OUT), .busy(busy)
  );

  always #5 CLK = ~CLK;

  // Model: queue of line levels for the current and upcoming cycles.
  bit exp_q[$];

  always @(posedge CLK or posedge rst) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      if (exp_q.size() == 0 && Data_valid === 1'b1) begin
        exp_q.push_back(1'b0);
        for (int i = 0; i < 8; i++) exp_q.push_back(P_DATA[i]);
        if (PAR_EN) exp_q.push_back((^P_DATA) ^ PAR_TYP);
        exp_q.push_back(1'b1);
      end
    end
  end

  task automatic chk(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %b, expected %b", name, $time, act, exp);
    end
  endtask

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge CLK) begin
    if (chk_en) begin
      chk("model_tx",   TX_OUT, (exp_q.size() > 0) ? exp_q[0] : 1'b1);
      chk("model_busy", busy,   exp_q.size() > 0);
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Walks one frame with literal expectations; scrambles inputs mid-frame and
  // applies the next request during the stop cycle.
  task automatic check_frame(input string name, input logic [10:0] exp, input int len,
                             input logic [7:0] nxt_d, input logic nxt_pe,
                             input logic nxt_pt, input logic nxt_v);
    for (int i = 0; i < len; i++) begin
      tick();
      chk({name, "_tx"},   TX_OUT, exp[i]);
      chk({name, "_busy"}, busy,   1'b1);
      if (i == 1) begin
        P_DATA  = P_DATA ^ 8'hA5;
        PAR_EN  = ~PAR_EN;
        PAR_TYP = ~PAR_TYP;
      end
      if (i == len - 1) begin
        P_DATA     = nxt_d;
        PAR_EN     = nxt_pe;
        PAR_TYP    = nxt_pt;
        Data_valid = nxt_v;
      end
    end
  endtask

  task automatic idle_cycles(input string name, input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      chk({name, "_tx"},   TX_OUT, 1'b1);
      chk({name, "_busy"}, busy,   1'b0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; P_DATA = 8'h00; Data_valid = 1'b0; PAR_EN = 1'b0; PAR_TYP = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    chk("reset_tx",   TX_OUT, 1'b1);
    chk("reset_busy", busy,   1'b0);
    rst = 1'b0;
    chk_en = 1'b1;
    idle_cycles("idle0", 10);

    // 8'b11010101, no parity, back-to-back into 8'h01 even parity
    P_DATA = 8'b11010101; PAR_EN = 1'b0; PAR_TYP = 1'b0; Data_valid = 1'b1;
    check_frame("f1", 11'b0_1110101010, 10, 8'h01, 1'b1, 1'b0, 1'b1);
    check_frame("f2", 11'b11000000010, 11, 8'h00, 1'b0, 1'b0, 1'b0);
    idle_cycles("idle1", 4);

    // Odd parity: 8'h03 -> parity 1, then 8'h07 -> parity 0
    P_DATA = 8'h03; PAR_EN = 1'b1; PAR_TYP = 1'b1; Data_valid = 1'b1;
    check_frame("f3", 11'b11000000110, 11, 8'h07, 1'b1, 1'b1, 1'b1);
    check_frame("f4", 11'b10000001110, 11, 8'h00, 1'b0, 1'b0, 1'b0);
    idle_cycles("idle2", 3);

    // Reset during data bit 4 (bit 4 of 8'hEF is 0 so the jump to 1 is visible)
    P_DATA = 8'hEF; PAR_EN = 1'b0; PAR_TYP = 1'b0; Data_valid = 1'b1;
    tick();
    Data_valid = 1'b0;
    repeat (5) tick();
    chk("bit4_tx",   TX_OUT, 1'b0);
    chk("bit4_busy", busy,   1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_tx",   TX_OUT, 1'b1);
    chk("async_rst_busy", busy,   1'b0);
    tick();
    rst = 1'b0;
    idle_cycles("post_rst", 12);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
